// File: rtl/video_frame_arbiter.sv
// rtl/video_frame_arbiter.sv - frame-granular round-robin arbiter sharing one registered 24-bit video sink between two sources
// Optional feature macro: VIDEO_ARB_BLANK_FILL_EN (arbiter emits black frames when nobody requests)
module video_frame_arbiter #(
    parameter int VISIBLE_WIDTH  = 800,
    parameter int VISIBLE_HEIGHT = 600
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    output logic [1:0]  grant,
    input  logic        src0_valid,
    input  logic [23:0] src0_video,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [23:0] src1_video,
    output logic        src1_ready,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_video,
    output logic        frame_start,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARB    = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [9:0] H_LAST = 10'(VISIBLE_WIDTH - 1);
    localparam logic [9:0] V_LAST = 10'(VISIBLE_HEIGHT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic        r_rr;
    logic        w_rr_nxt;
    logic        r_frame_start;
    logic        w_frame_start_nxt;
    logic [9:0]  r_h_count;
    logic [9:0]  r_v_count;
    logic        r_out_valid;
    logic [23:0] r_out_video;

    logic        w_load;
    logic        w_streaming;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_acc_blank;
    logic        w_accept;
    logic        w_last;
    logic        w_done;

`ifdef VIDEO_ARB_BLANK_FILL_EN
    logic        r_blank;
    logic        w_blank_nxt;
`endif

    assign w_load      = ~r_out_valid | out_ready;
    assign w_streaming = (r_state == S_STREAM);
    assign src0_ready  = r_grant[0] & w_load & w_streaming;
    assign src1_ready  = r_grant[1] & w_load & w_streaming;
    assign w_acc0      = src0_valid & src0_ready;
    assign w_acc1      = src1_valid & src1_ready;

`ifdef VIDEO_ARB_BLANK_FILL_EN
    assign w_acc_blank = r_blank & w_load & w_streaming;
`else
    assign w_acc_blank = 1'b0;
`endif

    assign w_accept = w_acc0 | w_acc1 | w_acc_blank;
    assign w_last   = w_accept & (r_h_count == H_LAST) & (r_v_count == V_LAST);
    // Final pixel sits in the output register; it is gone once the register may reload.
    assign w_done   = (r_state == S_DRAIN) & w_load;

    assign grant       = r_grant;
    assign out_valid   = r_out_valid;
    assign out_video   = r_out_video;
    assign frame_start = r_frame_start;
    assign frame_done  = w_done;

    // r_rr holds the index favoured on the next contested frame (the one not granted last).
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_rr_nxt          = r_rr;
        w_frame_start_nxt = 1'b0;
`ifdef VIDEO_ARB_BLANK_FILL_EN
        w_blank_nxt       = r_blank;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef VIDEO_ARB_BLANK_FILL_EN
                w_state_nxt = S_ARB;
`else
                if (req != 2'b00) begin
                    w_state_nxt = S_ARB;
                end
`endif
            end
            S_ARB: begin
                if (req != 2'b00) begin
                    w_state_nxt       = S_STREAM;
                    w_frame_start_nxt = 1'b1;
                    if (req == 2'b11) begin
                        w_grant_nxt = r_rr ? 2'b10 : 2'b01;
                    end else begin
                        w_grant_nxt = req;
                    end
                end else begin
`ifdef VIDEO_ARB_BLANK_FILL_EN
                    w_state_nxt       = S_STREAM;
                    w_frame_start_nxt = 1'b1;
                    w_blank_nxt       = 1'b1;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            S_STREAM: begin
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_done) begin
                    w_state_nxt = S_ARB;
                    w_grant_nxt = 2'b00;
`ifdef VIDEO_ARB_BLANK_FILL_EN
                    w_blank_nxt = 1'b0;
                    if (!r_blank) begin
                        w_rr_nxt = r_grant[0];
                    end
`else
                    w_rr_nxt = r_grant[0];
`endif
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_rr          <= 1'b0;
            r_frame_start <= 1'b0;
`ifdef VIDEO_ARB_BLANK_FILL_EN
            r_blank       <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_rr          <= w_rr_nxt;
            r_frame_start <= w_frame_start_nxt;
`ifdef VIDEO_ARB_BLANK_FILL_EN
            r_blank       <= w_blank_nxt;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_video <= 24'h000000;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_acc0) begin
                r_out_video <= src0_video;
            end else if (w_acc1) begin
                r_out_video <= src1_video;
            end else if (w_acc_blank) begin
                r_out_video <= 24'h000000;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_h_count <= 10'd0;
            r_v_count <= 10'd0;
        end else if (w_accept) begin
            if (r_h_count == H_LAST) begin
                r_h_count <= 10'd0;
                r_v_count <= (r_v_count == V_LAST) ? 10'd0 : r_v_count + 10'd1;
            end else begin
                r_h_count <= r_h_count + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_frame_arbiter.sv
// tb/tb_video_frame_arbiter.sv - self-checking bench for video_frame_arbiter (4x2 frames)
// Table-driven single-frame trace plus scoreboard-checked directed and random runs.
module tb_video_frame_arbiter;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int FP = W * H;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        src0_valid;
    logic [23:0] src0_video;
    logic        src0_ready;
    logic        src1_valid;
    logic [23:0] src1_video;
    logic        src1_ready;
    logic        out_ready;
    logic        out_valid;
    logic [23:0] out_video;
    logic        frame_start;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int src_cnt [2];

    video_frame_arbiter #(.VISIBLE_WIDTH(W), .VISIBLE_HEIGHT(H)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .src0_valid  (src0_valid),
        .src0_video  (src0_video),
        .src0_ready  (src0_ready),
        .src1_valid  (src1_valid),
        .src1_video  (src1_video),
        .src1_ready  (src1_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_video   (out_video),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    typedef struct {
        logic [1:0]  req;
        logic        v0;
        logic [23:0] d0;
        logic        ordy;
        logic [1:0]  e_grant;
        logic        e_ov;
        logic [23:0] e_od;
        logic        e_fs;
        logic        e_fd;
        logic        e_r0;
        logic        e_r1;
    } vec_t;

    vec_t tbl [12];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int s, input int n);
        return {8'(s + 1), 16'(n)};
    endfunction

    function automatic logic [1:0] onehot(input int o);
        return (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00;
    endfunction

    task automatic apply_reset();
        reset      = 1'b1;
        req        = 2'b00;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        src0_video = 24'h0;
        src1_video = 24'h0;
        out_ready  = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_video", 32'(out_video), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
    endtask

    // Expected output stream: per frame, the owner follows the request rule (alternate under
    // contention starting with source 0 after reset); each owner supplies its next FP pixels.
    task automatic run_frames(input logic [1:0] rq, input int nframes, input int vmode,
                              input int rmode, input int drop_after, input int abort_after);
        int          owner_q [$];
        logic [23:0] exp_q [$];
        bit          last_q [$];
        int          tmp_cnt [2];
        int          fav;
        int          o;
        int          acc_total;
        int          done_cnt;
        int          fs_cnt;
        int          cyc;
        int          acc_owner;
        logic        exp_fd;
        logic        hs;
        logic [1:0]  rq_now;

        tmp_cnt = src_cnt;
        fav     = 0;
        for (int f = 0; f < nframes; f++) begin
            if (rq == 2'b11) begin
                o   = fav;
                fav = 1 - fav;
            end else if (rq == 2'b01) begin
                o = 0;
            end else if (rq == 2'b10) begin
                o = 1;
            end else begin
                o = 2;
            end
            owner_q.push_back(o);
            for (int k = 0; k < FP; k++) begin
                if (o == 2) begin
                    exp_q.push_back(24'h000000);
                end else begin
                    exp_q.push_back(pix(o, tmp_cnt[o]));
                    tmp_cnt[o]++;
                end
                last_q.push_back(k == FP - 1);
            end
        end

        acc_total = 0;
        done_cnt  = 0;
        fs_cnt    = 0;
        cyc       = 0;
        rq_now    = rq;
        while (done_cnt < nframes && cyc < 3000) begin
            if (drop_after >= 0 && acc_total >= drop_after) rq_now = 2'b00;
            req        = rq_now;
            src0_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            src1_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            src0_video = pix(0, src_cnt[0]);
            src1_video = pix(1, src_cnt[1]);
            out_ready  = (rmode == 0) ? 1'b1 :
                         (rmode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
            #1;
            acc_owner = (acc_total / FP < nframes) ? owner_q[acc_total / FP] : 3;
            if (acc_owner != 0) check("nonowner_src0_ready", 32'(src0_ready), 32'd0);
            if (acc_owner != 1) check("nonowner_src1_ready", 32'(src1_ready), 32'd0);

            exp_fd = 1'b0;
            hs     = out_valid & out_ready;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 32'(out_valid), 32'd0);
                end else begin
                    check("out_video", 32'(out_video), 32'(exp_q[0]));
                    exp_fd = hs & last_q[0];
                end
            end
            check("frame_done", 32'(frame_done), 32'(exp_fd));

            if (frame_start) begin
                if (fs_cnt < nframes) check("start_grant", 32'(grant), 32'(onehot(owner_q[fs_cnt])));
                fs_cnt++;
            end
            if (hs && exp_q.size() > 0) begin
                check("grant_at_out", 32'(grant), 32'(onehot(owner_q[done_cnt])));
                void'(exp_q.pop_front());
                void'(last_q.pop_front());
                if (exp_fd) done_cnt++;
            end
            if (src0_valid && src0_ready) begin
                src_cnt[0]++;
                acc_total++;
            end
            if (src1_valid && src1_ready) begin
                src_cnt[1]++;
                acc_total++;
            end
            @(posedge clock);
            #2;
            cyc++;
            if (abort_after >= 0 && acc_total >= abort_after) break;
        end
        if (abort_after < 0) begin
            check("frames_completed", 32'(done_cnt), 32'(nframes));
            check("frame_starts", 32'(fs_cnt), 32'(nframes));
        end
    endtask

    initial begin
        src_cnt[0] = 0;
        src_cnt[1] = 0;

        //           req    v0    d0     rdy  | grant  ov    od     fs    fd    r0    r1
        tbl[0]  = '{2'b01, 1'b1, 24'd1, 1'b1, 2'b00, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b01, 1'b1, 24'd1, 1'b1, 2'b00, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b01, 1'b1, 24'd1, 1'b1, 2'b01, 1'b0, 24'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 1'b1, 24'd2, 1'b1, 2'b01, 1'b1, 24'd1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2'b01, 1'b1, 24'd3, 1'b1, 2'b01, 1'b1, 24'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{2'b01, 1'b1, 24'd4, 1'b1, 2'b01, 1'b1, 24'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 1'b1, 24'd5, 1'b1, 2'b01, 1'b1, 24'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 1'b1, 24'd6, 1'b1, 2'b01, 1'b1, 24'd5, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b01, 1'b1, 24'd7, 1'b1, 2'b01, 1'b1, 24'd6, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b01, 1'b1, 24'd8, 1'b1, 2'b01, 1'b1, 24'd7, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 1'b0, 24'd0, 1'b1, 2'b01, 1'b1, 24'd8, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 1'b0, 24'd0, 1'b1, 2'b00, 1'b0, 24'd8, 1'b0, 1'b0, 1'b0, 1'b0};

        apply_reset();
        for (int i = 0; i < 12; i++) begin
            req        = tbl[i].req;
            src0_valid = tbl[i].v0;
            src0_video = tbl[i].d0;
            out_ready  = tbl[i].ordy;
            src1_valid = 1'b1;
            src1_video = 24'hABCDEF;
            #1;
            check($sformatf("t%0d_grant", i), 32'(grant), 32'(tbl[i].e_grant));
            check($sformatf("t%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("t%0d_out_video", i), 32'(out_video), 32'(tbl[i].e_od));
            check($sformatf("t%0d_frame_start", i), 32'(frame_start), 32'(tbl[i].e_fs));
            check($sformatf("t%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].e_fd));
            check($sformatf("t%0d_src0_ready", i), 32'(src0_ready), 32'(tbl[i].e_r0));
            check($sformatf("t%0d_src1_ready", i), 32'(src1_ready), 32'(tbl[i].e_r1));
            @(posedge clock);
            #2;
        end

        // round robin under continuous contention
        apply_reset();
        run_frames(2'b11, 4, 0, 0, -1, -1);

        // backpressure: out_ready toggles every cycle
        apply_reset();
        run_frames(2'b01, 1, 0, 1, -1, -1);

        // request withdrawn after pixel 3: owner still finishes its frame
        apply_reset();
        run_frames(2'b01, 1, 0, 0, 3, -1);
        req        = 2'b00;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #2;
        end
`ifndef VIDEO_ARB_BLANK_FILL_EN
        check("drop_idle_out_valid", 32'(out_valid), 32'd0);
        check("drop_idle_grant", 32'(grant), 32'd0);
        check("drop_idle_frame_start", 32'(frame_start), 32'd0);
`endif

        // asynchronous reset after pixel 5, then a clean frame from h=0,v=0
        apply_reset();
        run_frames(2'b01, 1, 0, 0, -1, 5);
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_grant", 32'(grant), 32'd0);
        check("async_frame_done", 32'(frame_done), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        run_frames(2'b01, 1, 0, 0, -1, -1);

        // randomized valid / ready traffic
        apply_reset();
        run_frames(2'b11, 6, 1, 2, -1, -1);
        apply_reset();
        run_frames(2'b10, 2, 1, 2, -1, -1);

`ifdef VIDEO_ARB_BLANK_FILL_EN
        apply_reset();
        run_frames(2'b00, 3, 0, 0, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
